// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART-to-ALU command sequencer.
// Holds the state encoding, the settle length and the flag bit positions of the reply byte.
package alu_uart_pkg;

    typedef enum logic [2:0] {
        GET_A    = 3'd0,
        GET_B    = 3'd1,
        GET_OP   = 3'd2,
        SETTLE   = 3'd3,
        SEND_RES = 3'd4,
        WAIT_RES = 3'd5,
        SEND_FLG = 3'd6,
        WAIT_FLG = 3'd7
    } state_t;

    localparam int SETTLE_CYC = 2;
    localparam int FLG_ZERO   = 0;
    localparam int FLG_OVF    = 1;

    // True in the states that accept command bytes.
    function automatic logic is_rx_state(input state_t s);
        return (s == GET_A) || (s == GET_B) || (s == GET_OP);
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Counts idle cycles while running and flags expiry when the count reaches TIMEOUT_CYC.
// A TIMEOUT_CYC of zero removes the counter entirely.
module inactivity_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{i_clk, i_rst, i_clear, i_run};
            assign o_expired     = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYC + 1);
            logic [CW-1:0] cnt_reg;

            // Expiry is flagged in the cycle that would bring the count to TIMEOUT_CYC,
            // so the owner reacts on exactly that edge; a clear in the same cycle wins.
            assign o_expired = i_run && !i_clear && (cnt_reg == CW'(TIMEOUT_CYC - 1));

            always_ff @(posedge i_clk) begin
                if (i_rst || i_clear) begin
                    cnt_reg <= '0;
                end else if (i_run && !o_expired) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects A, B and opcode bytes from the UART, drives the registered ALU top,
// then returns the result byte followed by a flags byte to the UART transmitter.
module alu_uart_ctrl
    import alu_uart_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int NB_UART     = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_UART-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_zero,
    input  logic               i_alu_overflow,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_en_a,
    output logic               o_en_b,
    output logic               o_en_op,
    output logic [NB_UART-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err
);

    generate
        if (NB_DATA > NB_UART) begin : g_bad_data_width
            $error("alu_uart_ctrl: NB_DATA must not exceed NB_UART");
        end
        if (NB_OP > NB_UART) begin : g_bad_op_width
            $error("alu_uart_ctrl: NB_OP must not exceed NB_UART");
        end
        if (NB_UART < 2) begin : g_bad_uart_width
            $error("alu_uart_ctrl: NB_UART must hold both flag bits");
        end
    endgenerate

    state_t             state_reg,      state_next;
    logic [NB_DATA-1:0] data_a_reg,     data_a_next;
    logic [NB_DATA-1:0] data_b_reg,     data_b_next;
    logic [NB_OP-1:0]   op_reg,         op_next;
    logic               en_a_reg,       en_a_next;
    logic               en_b_reg,       en_b_next;
    logic               en_op_reg,      en_op_next;
    logic [NB_UART-1:0] tx_data_reg,    tx_data_next;
    logic               tx_start_reg,   tx_start_next;
    logic               busy_reg,       busy_next;
    logic               err_reg,        err_next;
    logic [1:0]         settle_cnt_reg, settle_cnt_next;
    logic [NB_DATA-1:0] res_reg,        res_next;
    logic               zero_reg,       zero_next;
    logic               ovf_reg,        ovf_next;

    logic timer_run;
    logic timer_clear;
    logic timer_expired;

    // Only the gaps between bytes of one command are timed; every byte restarts the count.
    assign timer_run   = (state_reg == GET_B) || (state_reg == GET_OP);
    assign timer_clear = i_rx_done || !timer_run;

    inactivity_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (timer_clear),
        .i_run     (timer_run),
        .o_expired (timer_expired)
    );

    always_comb begin
        state_next      = state_reg;
        data_a_next     = data_a_reg;
        data_b_next     = data_b_reg;
        op_next         = op_reg;
        en_a_next       = 1'b0;
        en_b_next       = 1'b0;
        en_op_next      = 1'b0;
        tx_data_next    = tx_data_reg;
        tx_start_next   = 1'b0;
        err_next        = 1'b0;
        settle_cnt_next = settle_cnt_reg;
        res_next        = res_reg;
        zero_next       = zero_reg;
        ovf_next        = ovf_reg;

        case (state_reg)
            GET_A: begin
                if (i_rx_done) begin
                    data_a_next = i_rx_data[NB_DATA-1:0];
                    en_a_next   = 1'b1;
                    state_next  = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done) begin
                    data_b_next = i_rx_data[NB_DATA-1:0];
                    en_b_next   = 1'b1;
                    state_next  = GET_OP;
                end else if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = GET_A;
                end
            end
            GET_OP: begin
                if (i_rx_done) begin
                    op_next         = i_rx_data[NB_OP-1:0];
                    en_op_next      = 1'b1;
                    settle_cnt_next = '0;
                    state_next      = SETTLE;
                end else if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = GET_A;
                end
            end
            SETTLE: begin
                // First cycle: ALU top registers load. Second: its combinational result is valid.
                if (settle_cnt_reg == 2'(SETTLE_CYC - 1)) begin
                    res_next   = i_alu_result;
                    zero_next  = i_alu_zero;
                    ovf_next   = i_alu_overflow;
                    state_next = SEND_RES;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            SEND_RES: begin
                tx_start_next = 1'b1;
                tx_data_next  = NB_UART'(res_reg);
                state_next    = WAIT_RES;
            end
            WAIT_RES: begin
                if (i_tx_done) begin
                    state_next = SEND_FLG;
                end
            end
            SEND_FLG: begin
                tx_start_next          = 1'b1;
                tx_data_next           = '0;
                tx_data_next[FLG_ZERO] = zero_reg;
                tx_data_next[FLG_OVF]  = ovf_reg;
                state_next             = WAIT_FLG;
            end
            WAIT_FLG: begin
                if (i_tx_done) begin
                    state_next = GET_A;
                end
            end
            default: begin
                state_next = GET_A;
            end
        endcase

        // A byte arriving while a command is in flight is lost; report it.
        if (i_rx_done && !is_rx_state(state_reg)) begin
            err_next = 1'b1;
        end

        busy_next = (state_next != GET_A);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= GET_A;
            data_a_reg     <= '0;
            data_b_reg     <= '0;
            op_reg         <= '0;
            en_a_reg       <= 1'b0;
            en_b_reg       <= 1'b0;
            en_op_reg      <= 1'b0;
            tx_data_reg    <= '0;
            tx_start_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
            settle_cnt_reg <= '0;
            res_reg        <= '0;
            zero_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            data_a_reg     <= data_a_next;
            data_b_reg     <= data_b_next;
            op_reg         <= op_next;
            en_a_reg       <= en_a_next;
            en_b_reg       <= en_b_next;
            en_op_reg      <= en_op_next;
            tx_data_reg    <= tx_data_next;
            tx_start_reg   <= tx_start_next;
            busy_reg       <= busy_next;
            err_reg        <= err_next;
            settle_cnt_reg <= settle_cnt_next;
            res_reg        <= res_next;
            zero_reg       <= zero_next;
            ovf_reg        <= ovf_next;
        end
    end

    assign o_data_a   = data_a_reg;
    assign o_data_b   = data_b_reg;
    assign o_op       = op_reg;
    assign o_en_a     = en_a_reg;
    assign o_en_b     = en_b_reg;
    assign o_en_op    = en_op_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_tx_start = tx_start_reg;
    assign o_busy     = busy_reg;
    assign o_err      = err_reg;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl: stimulus pushes expectations, a monitor pops and compares.
// The ALU top is stubbed in the bench; the reference model computes replies with plain integer arithmetic.
module tb_alu_uart_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_overflow;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic       en_a;
    logic       en_b;
    logic       en_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tx_delay = 2;
    int pending_err = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [5:0] exp_op[$];
    logic [8:0] exp_tx[$];   // bit 8 marks the result byte (latency-checked)

    alu_uart_ctrl #(
        .NB_DATA     (8),
        .NB_OP       (6),
        .NB_UART     (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rx_data      (rx_data),
        .i_rx_done      (rx_done),
        .i_tx_done      (tx_done),
        .i_alu_result   (alu_result),
        .i_alu_zero     (alu_zero),
        .i_alu_overflow (alu_overflow),
        .o_data_a       (data_a),
        .o_data_b       (data_b),
        .o_op           (op),
        .o_en_a         (en_a),
        .o_en_b         (en_b),
        .o_en_op        (en_op),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .o_busy         (busy),
        .o_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // ALU top stub: registers load on the enables, combinational ALU behind them.
    logic [7:0] stub_a, stub_b;
    logic [5:0] stub_op;
    always_ff @(posedge clk) begin
        if (en_a)  stub_a  <= data_a;
        if (en_b)  stub_b  <= data_b;
        if (en_op) stub_op <= op;
    end

    always_comb begin
        alu_result   = 8'h00;
        alu_overflow = 1'b0;
        case (stub_op[2:0])
            3'd0: begin
                alu_result   = stub_a + stub_b;
                alu_overflow = (stub_a[7] == stub_b[7]) && (alu_result[7] != stub_a[7]);
            end
            3'd1: begin
                alu_result   = stub_a - stub_b;
                alu_overflow = (stub_a[7] != stub_b[7]) && (alu_result[7] != stub_a[7]);
            end
            3'd2: alu_result = stub_a & stub_b;
            3'd3: alu_result = stub_a | stub_b;
            3'd4: alu_result = stub_a ^ stub_b;
            3'd5: alu_result = ~(stub_a | stub_b);
            3'd6: alu_result = stub_a >> 1;
            default: alu_result = stub_a;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    // Reference: returns {ovf, zero, result[7:0]} from signed-integer arithmetic.
    function automatic int alu_ref(input int a, input int b, input int opc);
        int sa, sb, r, ovf;
        sa  = (a > 127) ? a - 256 : a;
        sb  = (b > 127) ? b - 256 : b;
        ovf = 0;
        case (opc % 8)
            0: begin r = sa + sb; ovf = (r > 127 || r < -128) ? 1 : 0; end
            1: begin r = sa - sb; ovf = (r > 127 || r < -128) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - (a | b);
            6: r = a / 2;
            default: r = a;
        endcase
        r = r & 255;
        return r + ((r == 0) ? 256 : 0) + ovf * 512;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
        int r;
        int opt;
        opt = int'(opb) % 64;
        r   = alu_ref(int'(a), int'(b), opt);
        exp_a.push_back(a);
        exp_b.push_back(b);
        exp_op.push_back(6'(opt));
        exp_tx.push_back({1'b1, 8'(r % 256)});
        exp_tx.push_back({1'b0, 6'b0, 1'((r / 512) % 2), 1'((r / 256) % 2)});
        $display("cmd: a=%02h b=%02h op=%02h -> reply %02h %02h", a, b, opt, r % 256, (r / 256) % 4);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1 rx_data = b; rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb, input int gmax);
        push_cmd(a, b, opb);
        send_byte(a, $urandom_range(0, gmax));
        send_byte(b, $urandom_range(0, gmax));
        send_byte(opb, $urandom_range(0, gmax));
        wait_idle();
    endtask

    // UART transmitter model
    initial begin
        int d;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && rst === 1'b0) begin
                d = $urandom_range(tx_delay, tx_delay + 2);
                repeat (d) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an enable, a tx request or an error.
    initial begin
        logic prev_a, prev_b, prev_op, prev_err, outstanding;
        logic [8:0] e;
        int en_op_cyc;
        prev_a = 0; prev_b = 0; prev_op = 0; prev_err = 0; outstanding = 0; en_op_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst === 1'b1) outstanding = 1'b0;
            if (tx_done === 1'b1) outstanding = 1'b0;
            if (en_a === 1'b1) begin
                chk("en_a_width", 32'(prev_a), 32'd0);
                chk("en_a_pending", 32'(exp_a.size() > 0), 32'd1);
                if (exp_a.size() > 0) chk("data_a", 32'(data_a), 32'(exp_a.pop_front()));
            end
            if (en_b === 1'b1) begin
                chk("en_b_width", 32'(prev_b), 32'd0);
                chk("en_b_pending", 32'(exp_b.size() > 0), 32'd1);
                if (exp_b.size() > 0) chk("data_b", 32'(data_b), 32'(exp_b.pop_front()));
            end
            if (en_op === 1'b1) begin
                chk("en_op_width", 32'(prev_op), 32'd0);
                chk("en_op_pending", 32'(exp_op.size() > 0), 32'd1);
                if (exp_op.size() > 0) chk("op", 32'(op), 32'(exp_op.pop_front()));
                en_op_cyc = cyc;
            end
            if (tx_start === 1'b1) begin
                chk("tx_overlap", 32'(outstanding), 32'd0);
                outstanding = 1'b1;
                chk("tx_pending", 32'(exp_tx.size() > 0), 32'd1);
                if (exp_tx.size() > 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(e[7:0]));
                    if (e[8]) chk("tx_latency", 32'(cyc - en_op_cyc), 32'd3);
                    $display("tx: byte=%02h expected=%02h", tx_data, e[7:0]);
                end
            end
            if (err === 1'b1) begin
                chk("err_width", 32'(prev_err), 32'd0);
                chk("err_pending", 32'(pending_err > 0), 32'd1);
                if (pending_err > 0) pending_err--;
                $display("err: pulse at cycle %0d", cyc);
            end
            prev_a = en_a; prev_b = en_b; prev_op = en_op; prev_err = err;
        end
    end

    initial begin
        int n;
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00;

        // Reset held three cycles with bytes strobing in
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_outputs", 32'({data_a, data_b, op, en_a, en_b, en_op, tx_data, tx_start, busy, err}), 32'd0);
            rx_done = ~rx_done;
            rx_data = 8'($urandom);
        end
        rst = 1'b0; rx_done = 1'b0;
        @(posedge clk);
        #1 chk("busy_after_reset", 32'(busy), 32'd0);

        // Normal command and the both-flags reply
        send_cmd(8'h05, 8'h0A, 8'h20, 0);
        send_cmd(8'h80, 8'h80, 8'h20, 2);

        // Timeout after the first byte
        exp_a.push_back(8'h11);
        pending_err++;
        send_byte(8'h11, 0);
        n = 0;
        while (err !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("timeout_latency", 32'(n), 32'd16);
        @(posedge clk);
        #1 chk("busy_after_timeout", 32'(busy), 32'd0);
        send_cmd(8'h22, 8'h33, 8'h01, 3);

        // Bytes landing exactly on the expiry edge are accepted without error
        push_cmd(8'h44, 8'h7F, 8'h20);
        send_byte(8'h44, 0);
        send_byte(8'h7F, 14);
        send_byte(8'h20, 14);
        wait_idle();

        // Byte dropped while waiting for the transmitter
        tx_delay = 8;
        push_cmd(8'h12, 8'h34, 8'h22);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        send_byte(8'h22, 1);
        n = 0;
        while (tx_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drop_tx_seen", 32'(tx_start), 32'd1);
        pending_err++;
        send_byte(8'h55, 0);
        wait_idle();
        tx_delay = 2;

        // Opcode truncation
        send_cmd(8'h3C, 8'h5A, 8'hE5, 1);

        // Reset during SETTLE abandons the command
        exp_a.push_back(8'h09);
        exp_b.push_back(8'h07);
        exp_op.push_back(6'h01);
        send_byte(8'h09, 0);
        send_byte(8'h07, 0);
        send_byte(8'h01, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("busy_after_settle_reset", 32'(busy), 32'd0);
        chk("tx_after_settle_reset", 32'(tx_start), 32'd0);
        repeat (12) @(posedge clk);
        #1 chk("busy_still_idle", 32'(busy), 32'd0);

        // Randomised commands
        for (int i = 0; i < 12; i++) begin
            tx_delay = $urandom_range(1, 5);
            send_cmd(8'($urandom), 8'($urandom), 8'($urandom), 6);
        end

        repeat (5) @(posedge clk);
        chk("exp_a_drained", 32'(exp_a.size()), 32'd0);
        chk("exp_b_drained", 32'(exp_b.size()), 32'd0);
        chk("exp_op_drained", 32'(exp_op.size()), 32'd0);
        chk("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
        chk("err_drained", 32'(pending_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
